// File: rtl/pps_monitor.sv
// pps_monitor: receive-side checker for the active-low PPS line and the
// secondary timing-pulse line. Measures the PPS period, the PPS low width and
// up to three pulse_in offsets per period. It also flags width errors,
// extra-pulse errors and loss of PPS.
// Optional glitch filter: define PPS_GLITCH_FILTER_EN.
module pps_monitor #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WID_W    = 16,
  parameter int unsigned W_MIN    = 1900,
  parameter int unsigned W_MAX    = 2100,
  parameter int unsigned TIMEOUT  = 1500000000,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             pps_in,
  input  logic             pulse_in,
  input  logic             mon_en_i,
  output logic [CNT_W-1:0] period_o,
  output logic [WID_W-1:0] width_o,
  output logic [CNT_W-1:0] ofs0_o,
  output logic [CNT_W-1:0] ofs1_o,
  output logic [CNT_W-1:0] ofs2_o,
  output logic [1:0]       pulse_cnt_o,
  output logic             meas_valid_o,
  output logic             err_width_o,
  output logic             err_pulse_o,
  output logic             timeout_o,
  output logic             locked_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOST = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // synchroniser stages, idle level is 1
  logic r_pps_s1, r_pps_s2;
  logic r_pul_s1, r_pul_s2;

  // conditioned line levels feeding edge detection
  logic w_pps_cur, w_pul_cur;
  logic r_pps_prev, r_pul_prev;
  logic w_pps_fall, w_pps_rise, w_pul_fall;

  // measurement working registers
  logic [CNT_W-1:0] r_period;
  logic [WID_W-1:0] r_width;
  logic             r_width_done;
  logic [CNT_W-1:0] r_slot0, r_slot1, r_slot2;
  logic [1:0]       r_pcnt;
  logic             r_extra;

  // FSM decode strobes
  logic w_start, w_close, w_tmo;
  logic w_width_bad;

  // output registers
  logic [CNT_W-1:0] r_period_o;
  logic [WID_W-1:0] r_width_o;
  logic [CNT_W-1:0] r_ofs0_o, r_ofs1_o, r_ofs2_o;
  logic [1:0]       r_pulse_cnt_o;
  logic             r_meas_valid;
  logic             r_err_width;
  logic             r_err_pulse;
  logic             r_timeout;
  logic             r_locked;

  // two-flop synchronisers for both asynchronous inputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_pps_s1 <= 1'b1;
      r_pps_s2 <= 1'b1;
      r_pul_s1 <= 1'b1;
      r_pul_s2 <= 1'b1;
    end else begin
      r_pps_s1 <= pps_in;
      r_pps_s2 <= r_pps_s1;
      r_pul_s1 <= pulse_in;
      r_pul_s2 <= r_pul_s1;
    end
  end

`ifdef PPS_GLITCH_FILTER_EN
  localparam int unsigned FCW = $clog2(FILT_LEN + 1);

  logic [1:0]     w_filt_in;
  logic [1:0]     r_filt;
  logic [FCW-1:0] r_fcnt [2];

  assign w_filt_in = {r_pul_s2, r_pps_s2};

  // output follows the input only after FILT_LEN consecutive differing samples
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_filt <= '1;
      for (int unsigned i = 0; i < 2; i++) begin
        r_fcnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_filt_in[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCW'(FILT_LEN - 1)) begin
          r_filt[i] <= w_filt_in[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FCW'(1);
        end
      end
    end
  end

  assign w_pps_cur = r_filt[0];
  assign w_pul_cur = r_filt[1];
`else
  assign w_pps_cur = r_pps_s2;
  assign w_pul_cur = r_pul_s2;
`endif

  // previous-value copies for edge detection
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_pps_prev <= 1'b1;
      r_pul_prev <= 1'b1;
    end else begin
      r_pps_prev <= w_pps_cur;
      r_pul_prev <= w_pul_cur;
    end
  end

  assign w_pps_fall = r_pps_prev & ~w_pps_cur;
  assign w_pps_rise = ~r_pps_prev & w_pps_cur;
  assign w_pul_fall = r_pul_prev & ~w_pul_cur;

  assign w_width_bad = (r_width < WID_W'(W_MIN)) || (r_width > WID_W'(W_MAX));

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and decode of start / close / timeout events
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_close = 1'b0;
    w_tmo   = 1'b0;
    if (!mon_en_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_LOST: begin
          if (w_pps_fall) begin
            w_next  = S_RUN;
            w_start = 1'b1;
          end
        end
        S_RUN: begin
          if (w_pps_fall) begin
            w_close = 1'b1;
          end else if (r_period == CNT_W'(TIMEOUT)) begin
            w_tmo  = 1'b1;
            w_next = S_LOST;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // measurement counters, offset slots and latched results
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_period      <= '0;
      r_width       <= '0;
      r_width_done  <= 1'b0;
      r_slot0       <= '0;
      r_slot1       <= '0;
      r_slot2       <= '0;
      r_pcnt        <= '0;
      r_extra       <= 1'b0;
      r_period_o    <= '0;
      r_width_o     <= '0;
      r_ofs0_o      <= '0;
      r_ofs1_o      <= '0;
      r_ofs2_o      <= '0;
      r_pulse_cnt_o <= '0;
      r_meas_valid  <= 1'b0;
      r_err_width   <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_timeout     <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_meas_valid <= w_close;
      if (!mon_en_i) begin
        r_period     <= '0;
        r_width      <= '0;
        r_width_done <= 1'b0;
        r_slot0      <= '0;
        r_slot1      <= '0;
        r_slot2      <= '0;
        r_pcnt       <= '0;
        r_extra      <= 1'b0;
        r_locked     <= 1'b0;
      end else if (w_start || w_close) begin
        if (w_close) begin
          r_period_o    <= r_period;
          r_width_o     <= r_width;
          r_ofs0_o      <= r_slot0;
          r_ofs1_o      <= r_slot1;
          r_ofs2_o      <= r_slot2;
          r_pulse_cnt_o <= r_pcnt;
          r_err_width   <= w_width_bad;
          r_err_pulse   <= r_extra;
          r_locked      <= 1'b1;
        end
        r_timeout    <= 1'b0;
        r_period     <= CNT_W'(1);
        // the fall cycle itself is the first low cycle
        r_width      <= WID_W'(1);
        r_width_done <= 1'b0;
        r_slot0      <= '0;
        r_slot1      <= '0;
        r_slot2      <= '0;
        r_extra      <= 1'b0;
        // a coincident pulse edge opens the new period at offset 0
        r_pcnt       <= w_pul_fall ? 2'd1 : 2'd0;
      end else if (r_state == S_RUN) begin
        if (w_tmo) begin
          r_timeout    <= 1'b1;
          r_locked     <= 1'b0;
          r_period     <= '0;
          r_width      <= '0;
          r_width_done <= 1'b0;
          r_slot0      <= '0;
          r_slot1      <= '0;
          r_slot2      <= '0;
          r_pcnt       <= '0;
          r_extra      <= 1'b0;
        end else begin
          r_period <= r_period + CNT_W'(1);
          if (!r_width_done) begin
            if (w_pps_rise) begin
              r_width_done <= 1'b1;
            end else if (!w_pps_cur && (r_width != '1)) begin
              r_width <= r_width + WID_W'(1);
            end
          end
          if (w_pul_fall) begin
            case (r_pcnt)
              2'd0: begin
                r_slot0 <= r_period;
                r_pcnt  <= 2'd1;
              end
              2'd1: begin
                r_slot1 <= r_period;
                r_pcnt  <= 2'd2;
              end
              2'd2: begin
                r_slot2 <= r_period;
                r_pcnt  <= 2'd3;
              end
              default: r_extra <= 1'b1;
            endcase
          end
        end
      end else begin
        r_period     <= '0;
        r_width      <= '0;
        r_width_done <= 1'b0;
        r_slot0      <= '0;
        r_slot1      <= '0;
        r_slot2      <= '0;
        r_pcnt       <= '0;
        r_extra      <= 1'b0;
      end
    end
  end

  assign period_o     = r_period_o;
  assign width_o      = r_width_o;
  assign ofs0_o       = r_ofs0_o;
  assign ofs1_o       = r_ofs1_o;
  assign ofs2_o       = r_ofs2_o;
  assign pulse_cnt_o  = r_pulse_cnt_o;
  assign meas_valid_o = r_meas_valid;
  assign err_width_o  = r_err_width;
  assign err_pulse_o  = r_err_pulse;
  assign timeout_o    = r_timeout;
  assign locked_o     = r_locked;

endmodule

// File: tb/tb_pps_monitor.sv
// Directed testbench for pps_monitor with hand-computed expected values.
module tb_pps_monitor;

  localparam int unsigned TMO = 20000;
`ifdef PPS_GLITCH_FILTER_EN
  localparam int unsigned LAT = 3 + 4;
`else
  localparam int unsigned LAT = 3;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        pps_in;
  logic        pulse_in;
  logic        mon_en_i;
  logic [31:0] period_o;
  logic [15:0] width_o;
  logic [31:0] ofs0_o, ofs1_o, ofs2_o;
  logic [1:0]  pulse_cnt_o;
  logic        meas_valid_o;
  logic        err_width_o;
  logic        err_pulse_o;
  logic        timeout_o;
  logic        locked_o;

  always #5 aclk = ~aclk;

  pps_monitor #(.TIMEOUT(TMO)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .pps_in      (pps_in),
    .pulse_in    (pulse_in),
    .mon_en_i    (mon_en_i),
    .period_o    (period_o),
    .width_o     (width_o),
    .ofs0_o      (ofs0_o),
    .ofs1_o      (ofs1_o),
    .ofs2_o      (ofs2_o),
    .pulse_cnt_o (pulse_cnt_o),
    .meas_valid_o(meas_valid_o),
    .err_width_o (err_width_o),
    .err_pulse_o (err_pulse_o),
    .timeout_o   (timeout_o),
    .locked_o    (locked_o)
  );

  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned last_fall = 0;
  int unsigned ofs_tab [5] = '{951, 3568, 4595, 4700, 4800};

  // strobe log, one entry per meas_valid_o cycle
  int          nstrobe = 0;
  logic [31:0] s_period [16];
  logic [15:0] s_width  [16];
  logic [31:0] s_ofs0 [16], s_ofs1 [16], s_ofs2 [16];
  logic [1:0]  s_cnt    [16];
  logic        s_ew [16], s_ep [16];

  // record the outputs on every strobe cycle
  always @(posedge aclk) begin
    #1;
    if (meas_valid_o === 1'b1) begin
      if (nstrobe < 16) begin
        s_period[nstrobe] = period_o;
        s_width[nstrobe]  = width_o;
        s_ofs0[nstrobe]   = ofs0_o;
        s_ofs1[nstrobe]   = ofs1_o;
        s_ofs2[nstrobe]   = ofs2_o;
        s_cnt[nstrobe]    = pulse_cnt_o;
        s_ew[nstrobe]     = err_width_o;
        s_ep[nstrobe]     = err_pulse_o;
      end
      nstrobe = nstrobe + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, " period"},  64'(period_o), 0);
    check_eq({tag, " width"},   64'(width_o), 0);
    check_eq({tag, " ofs0"},    64'(ofs0_o), 0);
    check_eq({tag, " ofs1"},    64'(ofs1_o), 0);
    check_eq({tag, " ofs2"},    64'(ofs2_o), 0);
    check_eq({tag, " pcnt"},    64'(pulse_cnt_o), 0);
    check_eq({tag, " valid"},   64'(meas_valid_o), 0);
    check_eq({tag, " err_w"},   64'(err_width_o), 0);
    check_eq({tag, " err_p"},   64'(err_pulse_o), 0);
    check_eq({tag, " timeout"}, 64'(timeout_o), 0);
    check_eq({tag, " locked"},  64'(locked_o), 0);
  endtask

  task automatic check_meas(input string tag, input int idx, input int unsigned per,
                            input int unsigned wid, input int unsigned o0,
                            input int unsigned o1, input int unsigned o2,
                            input int unsigned cnt, input bit ew, input bit ep);
    int k;
    k = idx % 16;
    check_eq({tag, " period"}, 64'(s_period[k]), 64'(per));
    check_eq({tag, " width"},  64'(s_width[k]),  64'(wid));
    check_eq({tag, " ofs0"},   64'(s_ofs0[k]),   64'(o0));
    check_eq({tag, " ofs1"},   64'(s_ofs1[k]),   64'(o1));
    check_eq({tag, " ofs2"},   64'(s_ofs2[k]),   64'(o2));
    check_eq({tag, " pcnt"},   64'(s_cnt[k]),    64'(cnt));
    check_eq({tag, " err_w"},  64'(s_ew[k]),     64'(ew));
    check_eq({tag, " err_p"},  64'(s_ep[k]),     64'(ep));
  endtask

  // drive ncyc cycles of a period: PPS low for wid cycles from k=0,
  // npul pulse_in lows of 10 cycles from ofs_tab, optional 2-cycle PPS glitch
  task automatic drive_period(input int unsigned wid, input int unsigned ncyc,
                              input int unsigned npul, input int unsigned glk);
    for (int unsigned k = 0; k < ncyc; k++) begin
      @(negedge aclk);
      if (k == 0) last_fall = cyc;
      pps_in = (k < wid) ? 1'b0 : 1'b1;
      if (glk != 0 && (k == glk || k == glk + 1)) pps_in = 1'b0;
      pulse_in = 1'b1;
      for (int unsigned j = 0; j < 5; j++) begin
        if (j < npul && k >= ofs_tab[j] && k < ofs_tab[j] + 10) pulse_in = 1'b0;
      end
    end
  endtask

  int nexp;
  int unsigned tgt;

  initial begin
    aresetn  = 1'b0;
    pps_in   = 1'b1;
    pulse_in = 1'b1;
    mon_en_i = 1'b1;
    repeat (3) @(negedge aclk);
    check_zero("reset");
    aresetn = 1'b1;

    // first fall only arms the monitor
    drive_period(2000, 14411, 3, 0);
    check_eq("p1 strobes", 64'(nstrobe), 0);
    check_eq("p1 locked", 64'(locked_o), 0);

    drive_period(2000, 14411, 3, 0);
    check_eq("p2 strobes", 64'(nstrobe), 1);
    check_meas("m0", 0, 14411, 2000, 951, 3568, 4595, 3, 0, 0);
    check_eq("p2 locked", 64'(locked_o), 1);

    drive_period(1500, 5000, 3, 0);
    check_eq("p3 strobes", 64'(nstrobe), 2);
    check_meas("m1", 1, 14411, 2000, 951, 3568, 4595, 3, 0, 0);

    drive_period(2000, 5000, 5, 0);
    check_eq("p4 strobes", 64'(nstrobe), 3);
    check_meas("m2 narrow", 2, 5000, 1500, 951, 3568, 4595, 3, 1, 0);
    check_eq("p4 locked", 64'(locked_o), 1);

    drive_period(2000, 5000, 3, 3000);
    check_meas("m3 extra", 3, 5000, 2000, 951, 3568, 4595, 3, 0, 1);
`ifdef PPS_GLITCH_FILTER_EN
    check_eq("p5 strobes", 64'(nstrobe), 4);
    drive_period(2000, 5000, 3, 0);
    check_eq("p6 strobes", 64'(nstrobe), 5);
    check_meas("m4 filtered", 4, 5000, 2000, 951, 3568, 4595, 3, 0, 0);
    nexp = 5;
`else
    check_eq("p5 strobes", 64'(nstrobe), 5);
    check_meas("m4 glitch a", 4, 3000, 2000, 951, 0, 0, 1, 0, 0);
    drive_period(2000, 5000, 3, 0);
    check_eq("p6 strobes", 64'(nstrobe), 6);
    check_meas("m5 glitch b", 5, 2000, 2, 568, 1595, 0, 2, 1, 0);
    nexp = 6;
`endif

    // PPS stops: timeout TMO cycles after the FSM saw the last fall
    tgt = last_fall + LAT + TMO - 1;
    while (cyc < tgt) begin
      @(posedge aclk);
      #1;
    end
    check_eq("pre-timeout", 64'(timeout_o), 0);
    check_eq("pre-timeout locked", 64'(locked_o), 1);
    @(posedge aclk);
    #1;
    check_eq("timeout", 64'(timeout_o), 1);
    check_eq("timeout locked", 64'(locked_o), 0);

    // restart: first fall clears timeout, second fall strobes
    drive_period(2000, 5000, 3, 0);
    check_eq("r1 timeout", 64'(timeout_o), 0);
    check_eq("r1 locked", 64'(locked_o), 0);
    check_eq("r1 strobes", 64'(nstrobe), 64'(nexp));
    drive_period(2000, 2500, 3, 0);
    check_eq("r2 strobes", 64'(nstrobe), 64'(nexp + 1));
    check_meas("restart", nexp, 5000, 2000, 951, 3568, 4595, 3, 0, 0);
    check_eq("r2 locked", 64'(locked_o), 1);
    nexp++;

    // one-cycle reset mid-period
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check_zero("midreset");
    @(negedge aclk);
    aresetn = 1'b1;

    drive_period(2000, 5000, 3, 0);
    check_eq("q1 strobes", 64'(nstrobe), 64'(nexp));
    check_eq("q1 locked", 64'(locked_o), 0);
    drive_period(2000, 100, 3, 0);
    check_eq("q2 strobes", 64'(nstrobe), 64'(nexp + 1));
    check_meas("after reset", nexp, 5000, 2000, 951, 3568, 4595, 3, 0, 0);

    // disable: lock drops, last measurement holds
    @(negedge aclk);
    mon_en_i = 1'b0;
    repeat (2) @(negedge aclk);
    check_eq("disable locked", 64'(locked_o), 0);
    check_eq("disable hold", 64'(period_o), 5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
